vram_arb: RTL and testbench
===========================

VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 SHALL have parameter RENDER_WINDOW, default 256, meaning cycles per scanline reserved for renderer priority.
REQ-002 SHALL have parameter CPU_SLOT_PERIOD, default 4, meaning one CPU slot every N window cycles (N >= 2).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_L  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port line_start  input  1  one-cycle pulse (scanline_en of the VGA timing block) that opens a render window.
REQ-006 SHALL have ports ren_req input 1 / ren_addr input 14 / ren_gnt output 1 / ren_rvalid output 1: renderer read port.
REQ-007 SHALL have ports cpu_req input 1 / cpu_we input 1 / cpu_addr input 14 / cpu_wdata input 8 / cpu_gnt output 1 / cpu_rvalid output 1: CPU data port.
REQ-008 SHALL have port rdata  output 8  registered-RAM read data shared by both requesters, qualified by ren_rvalid or cpu_rvalid.
REQ-009 SHALL have ports vram_addr output 14 / vram_we output 1 / vram_wdata output 8 / vram_rdata input 8: single-port VRAM, 1-cycle read latency.
REQ-010 SHALL have port window_active  output 1  high while render window open.
REQ-011 SHALL have port cpu_stall_cnt  output 16  saturating CPU wait-cycle count.

Function
REQ-012 SHALL implement FSM states IDLE and WINDOW; IDLE->WINDOW on line_start; WINDOW->IDLE when window counter reaches RENDER_WINDOW-1 without line_start.
REQ-013 SHALL, on line_start in WINDOW, restart window and slot counters to 0 and stay in WINDOW.
REQ-014 SHALL, in WINDOW, grant CPU when cpu_req and slot counter == CPU_SLOT_PERIOD-1, else grant renderer if ren_req, else grant CPU if cpu_req.
REQ-015 SHALL, in IDLE, grant CPU if cpu_req, else renderer if ren_req.
REQ-016 SHALL increment slot counter every WINDOW cycle, wrapping CPU_SLOT_PERIOD-1 -> 0; held at 0 in IDLE.
REQ-017 SHALL assert at most one of ren_gnt/cpu_gnt per cycle, combinationally in the request cycle; requester holds req/addr until gnt.
REQ-018 SHALL drive vram_addr/vram_we/vram_wdata from the granted requester same cycle; vram_we = cpu_gnt & cpu_we; idle cycles drive addr 0, we 0.
REQ-019 SHALL assert ren_rvalid (cpu_rvalid) exactly one cycle after a renderer grant (CPU read grant), with rdata = vram_rdata; no rvalid for CPU writes.
REQ-020 SHALL, in cpu_stall_cnt, count cycles with cpu_req & !cpu_gnt, saturating at 0xFFFF.

Reset
REQ-021 SHALL, on rst_L low at clk edge: state IDLE, counters 0, ren_rvalid/cpu_rvalid 0, cpu_stall_cnt 0, window_active 0.
REQ-022 SHALL drop any grant in flight on reset mid-operation; no rvalid follows a grant issued in the reset cycle.

Configuration
REQ-023 SHALL compile stall counter only when VRAM_ARB_STATS_EN is defined; otherwise cpu_stall_cnt tied 0 and no counter flops exist.

Structure
REQ-024 SHALL take VRAM_ADDR_W (14), VRAM_DATA_W (8) and arb state enum (IDLE, WINDOW) from shared package vdp_pkg.
REQ-025 SHALL build window and slot counters from the team's existing counter sub-module (clear/en style); no other sub-modules.

Verification
REQ-026 SHALL cover: ren_req and cpu_req held continuously, line_start at t0 -> cpu_gnt at window cycles 3,7,11..., ren_gnt all others, for 256 cycles.
REQ-027 SHALL cover: IDLE, both requesting -> cpu_gnt every cycle, ren_gnt never; window_active 0.
REQ-028 SHALL cover: CPU write 0xA5 to 0x0123 then CPU read 0x0123 -> vram_we one cycle, cpu_rvalid one cycle after read grant, rdata 0xA5.
REQ-029 SHALL cover: line_start again at window cycle 100 -> window counter restarts, window_active stays 1 through cycle 100+255.
REQ-030 SHALL cover: rst_L low during renderer read grant -> no ren_rvalid next cycle, state IDLE, all outputs at reset values.
REQ-031 SHALL cover (VRAM_ARB_STATS_EN): cpu_req blocked 3 cycles in window -> cpu_stall_cnt = 3; preload near 0xFFFF -> holds 0xFFFF.

Source files
------------

// File: rtl/vdp_pkg.sv
// vdp_pkg -- shared VDP definitions.
// Holds the VRAM geometry, the arbiter state encoding and the
// internal VRAM command bundle used by vram_arb.
package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } arb_state_e;

  // One cycle's worth of command presented to the single-port VRAM.
  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic                   we;
    logic [VRAM_DATA_W-1:0] wdata;
  } vram_cmd_t;

endpackage

// File: rtl/vram_arb_cnt.sv
// vram_arb_cnt -- clear/enable wrapping counter.
// Ports:
//   clk, rst_L : clock, synchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance by one, wrapping MAX -> 0
//   cnt        : current count
module vram_arb_cnt #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_L || clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == WIDTH'(MAX)) ? '0 : cnt + WIDTH'(1);
  end

endmodule

// File: rtl/vram_arb.sv
// vram_arb -- VRAM arbiter between the scanline renderer and the CPU.
// A line_start pulse opens a RENDER_WINDOW-cycle window in which the
// renderer has priority except for one guaranteed CPU slot every
// CPU_SLOT_PERIOD cycles. Outside the window the CPU has priority.
// Grants are combinational in the request cycle; read data comes back
// one cycle later on the shared rdata bus, tagged by ren_rvalid/cpu_rvalid.
// Ports:
//   clk, rst_L            : clock, synchronous active-low reset
//   line_start            : opens/restarts the render window
//   ren_*                 : renderer read port (req/addr/gnt/rvalid)
//   cpu_*                 : CPU read/write port (req/we/addr/wdata/gnt/rvalid)
//   rdata                 : read data for whichever rvalid is high
//   vram_*                : single-port VRAM, 1-cycle read latency
//   window_active         : render window open
//   cpu_stall_cnt         : saturating count of CPU wait cycles
// Build option: define VRAM_ARB_STATS_EN to build the stall counter;
// otherwise cpu_stall_cnt is tied to 0.
module vram_arb
  import vdp_pkg::*;
#(
  parameter int RENDER_WINDOW   = 256,
  parameter int CPU_SLOT_PERIOD = 4
) (
  input  logic                   clk,
  input  logic                   rst_L,
  input  logic                   line_start,
  input  logic                   ren_req,
  input  logic [VRAM_ADDR_W-1:0] ren_addr,
  output logic                   ren_gnt,
  output logic                   ren_rvalid,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [VRAM_ADDR_W-1:0] cpu_addr,
  input  logic [VRAM_DATA_W-1:0] cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [VRAM_DATA_W-1:0] rdata,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic                   vram_we,
  output logic [VRAM_DATA_W-1:0] vram_wdata,
  input  logic [VRAM_DATA_W-1:0] vram_rdata,
  output logic                   window_active,
  output logic [15:0]            cpu_stall_cnt
);

  localparam int WIN_W  = (RENDER_WINDOW > 1) ? $clog2(RENDER_WINDOW) : 1;
  localparam int SLOT_W = $clog2(CPU_SLOT_PERIOD);

  arb_state_e        state_q, state_d;
  logic [WIN_W-1:0]  win_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic              in_win, cnt_clr, win_last, cpu_slot;
  vram_cmd_t         cmd;

  assign in_win   = (state_q == WINDOW);
  // Counters sit at 0 outside the window, and line_start re-arms them so the
  // first window cycle is always position 0.
  assign cnt_clr  = !in_win || line_start;
  assign win_last = (win_cnt == WIN_W'(RENDER_WINDOW - 1));
  assign cpu_slot = (slot_cnt == SLOT_W'(CPU_SLOT_PERIOD - 1));

  vram_arb_cnt #(.WIDTH(WIN_W), .MAX(RENDER_WINDOW - 1)) u_win_cnt (
    .clk   (clk),
    .rst_L (rst_L),
    .clr   (cnt_clr),
    .en    (in_win),
    .cnt   (win_cnt)
  );

  vram_arb_cnt #(.WIDTH(SLOT_W), .MAX(CPU_SLOT_PERIOD - 1)) u_slot_cnt (
    .clk   (clk),
    .rst_L (rst_L),
    .clr   (cnt_clr),
    .en    (in_win),
    .cnt   (slot_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_L) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: line_start inside the window restarts it rather than closing it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (line_start) state_d = WINDOW;
      WINDOW:  if (!line_start && win_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant outputs
  always_comb begin
    ren_gnt       = 1'b0;
    cpu_gnt       = 1'b0;
    window_active = in_win;
    case (state_q)
      IDLE: begin
        cpu_gnt = cpu_req;
        ren_gnt = ren_req && !cpu_req;
      end
      WINDOW: begin
        // CPU wins its reserved slot, or any cycle the renderer leaves free.
        cpu_gnt = cpu_req && (cpu_slot || !ren_req);
        ren_gnt = ren_req && !(cpu_req && cpu_slot);
      end
      default: ;
    endcase
  end

  // VRAM command from whichever side holds the grant; idle cycles park at 0.
  always_comb begin
    cmd = '0;
    if (cpu_gnt) begin
      cmd.addr  = cpu_addr;
      cmd.we    = cpu_we;
      cmd.wdata = cpu_wdata;
    end else if (ren_gnt) begin
      cmd.addr  = ren_addr;
    end
  end

  assign vram_addr  = cmd.addr;
  assign vram_we    = cmd.we;
  assign vram_wdata = cmd.wdata;
  assign rdata      = vram_rdata;

  // Read-return tags track the RAM's one-cycle latency; writes return nothing.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      ren_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
    end else begin
      ren_rvalid <= ren_gnt;
      cpu_rvalid <= cpu_gnt && !cpu_we;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_L)
      stall_q <= '0;
    else if (cpu_req && !cpu_gnt && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign cpu_stall_cnt = stall_q;
`else
  assign cpu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb -- randomized self-checking bench for vram_arb.
// The reference model tracks the window as "position since line_start"
// and derives grants from the priority rules directly.
module tb_vram_arb;
  localparam int RW = 256;
  localparam int P  = 4;
`ifdef VRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_L, line_start;
  logic        ren_req, ren_gnt, ren_rvalid;
  logic [13:0] ren_addr;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata, rdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        window_active;
  logic [15:0] cpu_stall_cnt;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [0:16383];

  always #5 clk = ~clk;

  // Behavioural single-port RAM, registered read.
  always @(posedge clk) begin
    vram_rdata <= mem[vram_addr];
    if (vram_we) mem[vram_addr] <= vram_wdata;
  end

  vram_arb #(.RENDER_WINDOW(RW), .CPU_SLOT_PERIOD(P)) dut (
    .clk(clk), .rst_L(rst_L), .line_start(line_start),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_gnt(ren_gnt), .ren_rvalid(ren_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .window_active(window_active), .cpu_stall_cnt(cpu_stall_cnt)
  );

  // ---------------- reference model ----------------
  bit         m_win = 0;
  int         m_pos = 0;
  bit         m_ren_v = 0, m_cpu_v = 0;
  int         m_stall = 0;
  logic [7:0] m_rd = 8'h00;

  function automatic void exp_gnt(output bit ec, output bit er);
    bit slot;
    slot = m_win && ((m_pos % P) == P - 1);
    if (m_win) ec = cpu_req && (slot || !ren_req);
    else       ec = cpu_req;
    er = ren_req && !ec;
  endfunction

  function automatic logic [15:0] exp_stall();
    return STATS ? ((m_stall > 65535) ? 16'hFFFF : 16'(m_stall)) : 16'h0000;
  endfunction

  // Advance one clock and update the model with what this cycle should do.
  task automatic tick();
    bit ec, er;
    exp_gnt(ec, er);
    @(posedge clk);
    if (!rst_L) begin
      m_win = 0; m_pos = 0; m_ren_v = 0; m_cpu_v = 0; m_stall = 0;
    end else begin
      m_ren_v = er;
      m_cpu_v = ec && !cpu_we;
      if (er)                m_rd = mem[ren_addr];
      else if (ec && !cpu_we) m_rd = mem[cpu_addr];
      if (cpu_req && !ec && m_stall < 65535) m_stall++;
      if (line_start) begin
        m_win = 1; m_pos = 0;
      end else if (m_win) begin
        m_pos++;
        if (m_pos == RW) begin m_win = 0; m_pos = 0; end
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_L = 0; line_start = 0; ren_req = 0; cpu_req = 0; cpu_we = 0;
    tick(); tick();
    @(negedge clk);
    vectors++; if (window_active !== 1'b0) begin errors++; $display("FAIL reset_window_active got %b want 0", window_active); end
    vectors++; if (ren_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ren_rvalid got %b want 0", ren_rvalid); end
    vectors++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid got %b want 0", cpu_rvalid); end
    vectors++; if (cpu_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall got %h want 0", cpu_stall_cnt); end
    vectors++; if (vram_we !== 1'b0 || vram_addr !== 14'h0) begin errors++; $display("FAIL reset_vram got we=%b addr=%h want 0/0", vram_we, vram_addr); end
    tick();
    rst_L = 1;
  endtask

  task automatic test_idle_priority();
    bit ec, er;
    ren_req = 1; cpu_req = 1; cpu_we = 0;
    for (int i = 0; i < 12; i++) begin
      ren_addr = 14'($urandom); cpu_addr = 14'($urandom);
      exp_gnt(ec, er);
      @(negedge clk);
      vectors++; if (cpu_gnt !== 1'b1 || ren_gnt !== 1'b0) begin errors++; $display("FAIL idle_prio cyc %0d got cpu=%b ren=%b want 1/0", i, cpu_gnt, ren_gnt); end
      vectors++; if (window_active !== 1'b0) begin errors++; $display("FAIL idle_window cyc %0d got %b want 0", i, window_active); end
      vectors++; if (vram_addr !== cpu_addr) begin errors++; $display("FAIL idle_addr cyc %0d got %h want %h", i, vram_addr, cpu_addr); end
      vectors++; if (cpu_rvalid !== m_cpu_v) begin errors++; $display("FAIL idle_rvalid cyc %0d got %b want %b", i, cpu_rvalid, m_cpu_v); end
      tick();
    end
    ren_req = 0; cpu_req = 0;
  endtask

  task automatic test_window_slots();
    bit want_cpu;
    ren_req = 1; cpu_req = 1; cpu_we = 0; line_start = 1;
    tick();
    line_start = 0;
    for (int k = 0; k < RW; k++) begin
      want_cpu = ((k % P) == P - 1);
      @(negedge clk);
      vectors++; if (window_active !== 1'b1) begin errors++; $display("FAIL slots_window k=%0d got %b want 1", k, window_active); end
      vectors++; if (cpu_gnt !== want_cpu || ren_gnt !== !want_cpu) begin errors++; $display("FAIL slots_gnt k=%0d got cpu=%b ren=%b want cpu=%b", k, cpu_gnt, ren_gnt, want_cpu); end
      vectors++; if (cpu_stall_cnt !== exp_stall()) begin errors++; $display("FAIL slots_stall k=%0d got %h want %h", k, cpu_stall_cnt, exp_stall()); end
      tick();
    end
    @(negedge clk);
    vectors++; if (window_active !== 1'b0 || cpu_gnt !== 1'b1) begin errors++; $display("FAIL slots_close got win=%b cpu=%b want 0/1", window_active, cpu_gnt); end
    tick();
    ren_req = 0; cpu_req = 0;
  endtask

  task automatic test_ram_rw();
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0123; cpu_wdata = 8'hA5;
    @(negedge clk);
    vectors++; if (cpu_gnt !== 1'b1 || vram_we !== 1'b1) begin errors++; $display("FAIL rw_write got gnt=%b we=%b want 1/1", cpu_gnt, vram_we); end
    vectors++; if (vram_addr !== 14'h0123 || vram_wdata !== 8'hA5) begin errors++; $display("FAIL rw_wcmd got %h/%h want 0123/a5", vram_addr, vram_wdata); end
    tick();
    cpu_we = 0; cpu_wdata = 8'h00;
    @(negedge clk);
    vectors++; if (vram_we !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rw_read_cmd got we=%b rvalid=%b want 0/0", vram_we, cpu_rvalid); end
    tick();
    cpu_req = 0;
    @(negedge clk);
    vectors++; if (cpu_rvalid !== 1'b1 || rdata !== 8'hA5) begin errors++; $display("FAIL rw_rdata got rvalid=%b data=%h want 1/a5", cpu_rvalid, rdata); end
    vectors++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rw_we_drop got %b want 0", vram_we); end
    tick();
    @(negedge clk);
    vectors++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rw_rvalid_once got %b want 0", cpu_rvalid); end
    tick();
  endtask

  task automatic test_restart();
    bit ec, er;
    for (int k = 0; k <= 357; k++) begin
      line_start = (k == 0) || (k == 100);
      ren_req = 1'($urandom); cpu_req = 1'($urandom); cpu_we = 0;
      ren_addr = 14'($urandom); cpu_addr = 14'($urandom);
      exp_gnt(ec, er);
      @(negedge clk);
      if (k >= 1) begin
        vectors++; if (window_active !== (k <= 356)) begin errors++; $display("FAIL restart_window k=%0d got %b want %b", k, window_active, (k <= 356)); end
      end
      vectors++; if (cpu_gnt !== ec || ren_gnt !== er) begin errors++; $display("FAIL restart_gnt k=%0d got cpu=%b ren=%b want %b/%b", k, cpu_gnt, ren_gnt, ec, er); end
      tick();
    end
    line_start = 0; ren_req = 0; cpu_req = 0;
  endtask

  task automatic test_random();
    bit ec, er;
    logic [13:0] ea;
    for (int i = 0; i < 800; i++) begin
      line_start = (i == 5) || ($urandom_range(0, 299) == 0);
      ren_req = 1'($urandom); cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      ren_addr = 14'($urandom); cpu_addr = 14'($urandom); cpu_wdata = 8'($urandom);
      exp_gnt(ec, er);
      ea = ec ? cpu_addr : (er ? ren_addr : 14'h0);
      @(negedge clk);
      vectors++; if (cpu_gnt !== ec || ren_gnt !== er) begin errors++; $display("FAIL rand_gnt i=%0d got cpu=%b ren=%b want %b/%b", i, cpu_gnt, ren_gnt, ec, er); end
      vectors++; if (window_active !== m_win) begin errors++; $display("FAIL rand_window i=%0d got %b want %b", i, window_active, m_win); end
      vectors++; if (vram_addr !== ea || vram_we !== (ec && cpu_we)) begin errors++; $display("FAIL rand_vram i=%0d got %h/%b want %h/%b", i, vram_addr, vram_we, ea, ec && cpu_we); end
      vectors++; if (ren_rvalid !== m_ren_v || cpu_rvalid !== m_cpu_v) begin errors++; $display("FAIL rand_rvalid i=%0d got %b/%b want %b/%b", i, ren_rvalid, cpu_rvalid, m_ren_v, m_cpu_v); end
      if (m_ren_v || m_cpu_v) begin
        vectors++; if (rdata !== m_rd) begin errors++; $display("FAIL rand_rdata i=%0d got %h want %h", i, rdata, m_rd); end
      end
      vectors++; if (cpu_stall_cnt !== exp_stall()) begin errors++; $display("FAIL rand_stall i=%0d got %h want %h", i, cpu_stall_cnt, exp_stall()); end
      tick();
    end
    line_start = 0; ren_req = 0; cpu_req = 0; cpu_we = 0;
  endtask

  task automatic test_reset_mid();
    line_start = 1; ren_req = 1; cpu_req = 0; cpu_we = 0; ren_addr = 14'h0042;
    tick();
    line_start = 0;
    tick(); tick(); tick();
    rst_L = 0;
    tick();
    rst_L = 1; ren_req = 0;
    @(negedge clk);
    vectors++; if (ren_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %b/%b want 0/0", ren_rvalid, cpu_rvalid); end
    vectors++; if (window_active !== 1'b0) begin errors++; $display("FAIL rstmid_window got %b want 0", window_active); end
    vectors++; if (cpu_stall_cnt !== 16'h0 || vram_we !== 1'b0 || vram_addr !== 14'h0) begin errors++; $display("FAIL rstmid_outs got stall=%h we=%b addr=%h want 0", cpu_stall_cnt, vram_we, vram_addr); end
    vectors++; if (ren_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_gnt got %b/%b want 0/0", ren_gnt, cpu_gnt); end
    tick();
    ren_req = 1; cpu_req = 1;
    @(negedge clk);
    // IDLE favours the CPU; a live window at slot 0 would favour the renderer.
    vectors++; if (cpu_gnt !== 1'b1 || ren_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_idle got cpu=%b ren=%b want 1/0", cpu_gnt, ren_gnt); end
    tick();
    ren_req = 0; cpu_req = 0;
  endtask

  task automatic test_stats();
    rst_L = 0; tick(); rst_L = 1;
    line_start = 1; ren_req = 1; cpu_req = 0;
    tick();
    line_start = 0; cpu_req = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if (cpu_gnt !== (k == 3)) begin errors++; $display("FAIL stats_gnt k=%0d got %b want %b", k, cpu_gnt, (k == 3)); end
      tick();
    end
    cpu_req = 0;
    @(negedge clk);
    vectors++; if (cpu_stall_cnt !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL stats_three got %h want %h", cpu_stall_cnt, (STATS ? 16'd3 : 16'd0)); end
`ifdef VRAM_ARB_STATS_EN
    dut.stall_q = 16'hFFFD;
    m_stall = 65533;
`endif
    tick();
    cpu_req = 1;
    for (int k = 0; k < 8; k++) tick();
    cpu_req = 0;
    @(negedge clk);
    vectors++; if (cpu_stall_cnt !== exp_stall()) begin errors++; $display("FAIL stats_sat got %h want %h", cpu_stall_cnt, exp_stall()); end
    tick();
    ren_req = 0;
  endtask

  initial begin
    rst_L = 0; line_start = 0; ren_req = 0; cpu_req = 0; cpu_we = 0;
    ren_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
    #1;
    test_reset();
    test_idle_priority();
    test_window_slots();
    test_ram_rw();
    test_restart();
    test_random();
    test_reset_mid();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
